// File: rtl/fpnew_result_collector.sv
// In-order result collector for the FPU output side.
// Hands out sequence IDs at dispatch time and accepts out-of-order completions
// from the opgroup blocks, each tagged with the ID it was dispatched with.
// Completions are parked in a circular reorder buffer and retired strictly in
// dispatch order over one valid/ready port. Sticky exception flags are
// accumulated as entries retire.
module fpnew_result_collector #(
  parameter int Width       = 32,
  parameter int NumOpGroups = 4,
  parameter int Depth       = 8,
  localparam int IdWidth    = $clog2(Depth)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  // dispatch side
  input  logic                           alloc_valid_i,
  output logic                           alloc_ready_o,
  output logic [IdWidth-1:0]             alloc_id_o,
  // opgroup completion ports
  input  logic [NumOpGroups-1:0]         opg_valid_i,
  output logic [NumOpGroups-1:0]         opg_ready_o,
  input  logic [NumOpGroups*Width-1:0]   opg_result_i,
  input  logic [NumOpGroups*5-1:0]       opg_status_i,
  input  logic [NumOpGroups-1:0]         opg_ext_bit_i,
  input  logic [NumOpGroups*IdWidth-1:0] opg_id_i,
  // in-order retire port
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [Width-1:0]               result_o,
  output logic [4:0]                     status_o,
  output logic                           extension_bit_o,
  output logic [IdWidth-1:0]             out_id_o,
  // sticky flags and status
  input  logic                           fflags_clr_i,
  output logic [4:0]                     fflags_o,
  output logic                           busy_o
);

  localparam logic [IdWidth:0] DepthC = (IdWidth + 1)'(Depth);

  // Per-entry bookkeeping: allocated to an operation / result has arrived.
  logic [Depth-1:0]   r_alloc;
  logic [Depth-1:0]   r_done;

  // Per-entry payload.
  logic [Width-1:0]   r_result [Depth];
  logic [4:0]         r_status [Depth];
  logic [Depth-1:0]   r_ext;

  // Circular pointers and occupancy.
  logic [IdWidth-1:0] r_head;
  logic [IdWidth-1:0] r_tail;
  logic [IdWidth:0]   r_count;

  logic [4:0]         r_fflags;

  // Completion routing: per entry, which port (if any) targets it this cycle.
  logic [Depth-1:0]   w_cpl_hit;
  logic [Depth-1:0]   w_cpl_en;
  logic [Width-1:0]   w_cpl_result [Depth];
  logic [4:0]         w_cpl_status [Depth];
  logic [Depth-1:0]   w_cpl_ext;

  // Handshake qualifiers and next-state bookkeeping.
  logic               w_alloc_fire;
  logic               w_retire;
  logic [Depth-1:0]   w_alloc_nxt;
  logic [Depth-1:0]   w_done_nxt;

  // Dispatch handshake. Deliberately independent of this cycle's retire so
  // there is no combinational path from out_ready_i to alloc_ready_o.
  assign alloc_ready_o = (r_count < DepthC) & ~flush_i;
  assign alloc_id_o    = r_tail;
  assign w_alloc_fire  = alloc_valid_i & alloc_ready_o;

  // Completions are never back-pressured; stale or duplicate ones are dropped.
  assign opg_ready_o   = '1;

  // Retire port shows the head entry; flush masks it for the flushing cycle.
  assign out_valid_o     = r_alloc[r_head] & r_done[r_head] & ~flush_i;
  assign result_o        = r_result[r_head];
  assign status_o        = r_status[r_head];
  assign extension_bit_o = r_ext[r_head];
  assign out_id_o        = r_head;
  assign w_retire        = out_valid_o & out_ready_i;

  assign fflags_o = r_fflags;
  assign busy_o   = (r_count != '0);

  // Match every port tag against every entry; scanning ports from high to low
  // lets the lowest-indexed port win when two ports carry the same tag.
  always_comb begin
    for (int e = 0; e < Depth; e++) begin
      w_cpl_hit[e]    = 1'b0;
      w_cpl_result[e] = '0;
      w_cpl_status[e] = '0;
      w_cpl_ext[e]    = 1'b0;
      for (int p = NumOpGroups - 1; p >= 0; p--) begin
        if (opg_valid_i[p] && (opg_id_i[p*IdWidth +: IdWidth] == IdWidth'(e))) begin
          w_cpl_hit[e]    = 1'b1;
          w_cpl_result[e] = opg_result_i[p*Width +: Width];
          w_cpl_status[e] = opg_status_i[p*5 +: 5];
          w_cpl_ext[e]    = opg_ext_bit_i[p];
        end
      end
    end
  end

  // A completion lands only in an entry that was allocated and still pending
  // at the start of the cycle; an entry allocated this same cycle is not yet
  // eligible because its alloc bit is still low.
  assign w_cpl_en = w_cpl_hit & r_alloc & ~r_done & {Depth{~flush_i}};

  // Next alloc/done vectors from completions, retire and allocation.
  always_comb begin
    w_alloc_nxt = r_alloc;
    w_done_nxt  = r_done | w_cpl_en;
    if (w_retire) begin
      w_alloc_nxt[r_head] = 1'b0;
    end
    if (w_alloc_fire) begin
      w_alloc_nxt[r_tail] = 1'b1;
      w_done_nxt[r_tail]  = 1'b0;
    end
  end

  // Bookkeeping and pointer registers; flush returns everything to empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_alloc <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_alloc <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_alloc <= w_alloc_nxt;
      r_done  <= w_done_nxt;
      if (w_alloc_fire) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_retire) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_alloc_fire, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage, written by accepted completions only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < Depth; e++) begin
        r_result[e] <= '0;
        r_status[e] <= '0;
      end
      r_ext <= '0;
    end else begin
      for (int e = 0; e < Depth; e++) begin
        if (w_cpl_en[e]) begin
          r_result[e] <= w_cpl_result[e];
          r_status[e] <= w_cpl_status[e];
          r_ext[e]    <= w_cpl_ext[e];
        end
      end
    end
  end

  // Sticky flags: clear wins over history but still keeps a same-cycle retire.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fflags <= '0;
    end else if (fflags_clr_i) begin
      r_fflags <= w_retire ? r_status[r_head] : 5'b0;
    end else if (w_retire) begin
      r_fflags <= r_fflags | r_status[r_head];
    end
  end

endmodule

// File: tb/tb_fpnew_result_collector.sv
// Bench for fpnew_result_collector: directed scenarios followed by a random
// phase, with every cycle checked against a queue-based reference model.
module tb_fpnew_result_collector;

  localparam int W  = 32;
  localparam int NG = 4;
  localparam int D  = 8;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              alloc_valid_i;
  logic              alloc_ready_o;
  logic [IW-1:0]     alloc_id_o;
  logic [NG-1:0]     opg_valid_i;
  logic [NG-1:0]     opg_ready_o;
  logic [NG*W-1:0]   opg_result_i;
  logic [NG*5-1:0]   opg_status_i;
  logic [NG-1:0]     opg_ext_bit_i;
  logic [NG*IW-1:0]  opg_id_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [W-1:0]      result_o;
  logic [4:0]        status_o;
  logic              extension_bit_o;
  logic [IW-1:0]     out_id_o;
  logic              fflags_clr_i;
  logic [4:0]        fflags_o;
  logic              busy_o;

  always #5 clk = ~clk;

  fpnew_result_collector #(.Width(W), .NumOpGroups(NG), .Depth(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
    .opg_valid_i(opg_valid_i), .opg_ready_o(opg_ready_o), .opg_result_i(opg_result_i),
    .opg_status_i(opg_status_i), .opg_ext_bit_i(opg_ext_bit_i), .opg_id_i(opg_id_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .status_o(status_o), .extension_bit_o(extension_bit_o), .out_id_o(out_id_o),
    .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o), .busy_o(busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: dispatch-ordered queue of in-flight IDs plus per-ID data.
  int          q[$];
  logic        m_done [D];
  logic [W-1:0] m_res [D];
  logic [4:0]  m_st  [D];
  logic        m_ext [D];
  int          next_id;
  logic [4:0]  m_ff;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < D; i++) begin
      m_done[i] = 1'b0; m_res[i] = '0; m_st[i] = '0; m_ext[i] = 1'b0;
    end
    next_id = 0;
    m_ff    = '0;
  endtask

  function automatic bit in_flight(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    flush_i = 0; alloc_valid_i = 0; out_ready_i = 0; fflags_clr_i = 0;
    opg_valid_i = '0; opg_result_i = '0; opg_status_i = '0; opg_ext_bit_i = '0; opg_id_i = '0;
  endtask

  task automatic set_port(input int p, input int id, input logic [W-1:0] res,
                          input logic [4:0] st, input logic ext);
    opg_valid_i[p]          = 1'b1;
    opg_id_i[p*IW +: IW]    = IW'(id);
    opg_result_i[p*W +: W]  = res;
    opg_status_i[p*5 +: 5]  = st;
    opg_ext_bit_i[p]        = ext;
  endtask

  // One clock cycle: check outputs against the model with the current inputs,
  // advance the model, then let the clock edge happen.
  task automatic cycle();
    bit         exp_rdy, exp_v, retire;
    logic [D-1:0] snap, taken;
    int         id;
    #1;
    exp_rdy = (q.size() < D) && !flush_i;
    exp_v   = (q.size() > 0) && m_done[q[0]] && !flush_i;
    chk("alloc_ready", alloc_ready_o, exp_rdy);
    chk("alloc_id", alloc_id_o, next_id);
    chk("opg_ready", opg_ready_o, 4'hF);
    chk("out_valid", out_valid_o, exp_v);
    chk("busy", busy_o, q.size() != 0);
    chk("fflags", fflags_o, m_ff);
    if (exp_v) begin
      chk("out_id", out_id_o, q[0]);
      chk("result", result_o, m_res[q[0]]);
      chk("status", status_o, m_st[q[0]]);
      chk("ext", extension_bit_o, m_ext[q[0]]);
    end
    retire = exp_v && out_ready_i;
    if (fflags_clr_i) m_ff = retire ? m_st[q[0]] : 5'b0;
    else if (retire)  m_ff = m_ff | m_st[q[0]];
    if (flush_i) begin
      q.delete();
      for (int i = 0; i < D; i++) m_done[i] = 1'b0;
      next_id = 0;
    end else begin
      for (int i = 0; i < D; i++) snap[i] = m_done[i];
      taken = '0;
      for (int p = 0; p < NG; p++) begin
        id = int'(opg_id_i[p*IW +: IW]);
        if (opg_valid_i[p] && in_flight(id) && !snap[id] && !taken[id]) begin
          taken[id]  = 1'b1;
          m_done[id] = 1'b1;
          m_res[id]  = opg_result_i[p*W +: W];
          m_st[id]   = opg_status_i[p*5 +: 5];
          m_ext[id]  = opg_ext_bit_i[p];
        end
      end
      if (retire) void'(q.pop_front());
      if (alloc_valid_i && exp_rdy) begin
        q.push_back(next_id);
        m_done[next_id] = 1'b0;
        next_id = (next_id + 1) % D;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1;
    @(posedge clk);
    @(negedge clk);
    rst_i = 0;
    model_reset();
  endtask

  initial begin
    rst_i = 1;
    idle();
    model_reset();
    @(negedge clk);
    chk("rst_alloc_ready", alloc_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    @(negedge clk);
    rst_i = 0;

    // Three allocations completed out of order, retired in order.
    repeat (3) begin idle(); alloc_valid_i = 1; cycle(); end
    idle(); out_ready_i = 1; set_port(0, 2, 32'hAAAA_0002, 5'b0, 1'b0); cycle();
    idle(); out_ready_i = 1; set_port(1, 0, 32'hBBBB_0000, 5'b0, 1'b1); cycle();
    chk("tp1_v0", out_valid_o, 1);
    chk("tp1_id0", out_id_o, 0);
    chk("tp1_res0", result_o, 32'hBBBB_0000);
    idle(); out_ready_i = 1; set_port(2, 1, 32'hCCCC_0001, 5'b0, 1'b0); cycle();
    idle(); out_ready_i = 1;
    chk("tp1_id1", out_id_o, 1);
    chk("tp1_res1", result_o, 32'hCCCC_0001);
    cycle();
    chk("tp1_id2", out_id_o, 2);
    chk("tp1_res2", result_o, 32'hAAAA_0002);
    cycle();
    chk("tp1_idle", busy_o, 0);
    cycle();

    // Fill to Depth, then free one entry and see the ID wrap.
    do_reset();
    repeat (8) begin idle(); alloc_valid_i = 1; cycle(); end
    idle();
    chk("tp2_full_rdy", alloc_ready_o, 0);
    chk("tp2_full_busy", busy_o, 1);
    cycle();
    idle(); set_port(3, 0, 32'h1234_5678, 5'b0, 1'b0); cycle();
    idle(); out_ready_i = 1; cycle();
    idle(); alloc_valid_i = 1;
    chk("tp2_rdy_back", alloc_ready_o, 1);
    chk("tp2_wrap_id", alloc_id_o, 0);
    cycle();

    // All four ports complete in one cycle, then four back-to-back retires.
    do_reset();
    repeat (4) begin idle(); alloc_valid_i = 1; cycle(); end
    idle();
    for (int p = 0; p < NG; p++) set_port(p, p, 32'h100 + p, 5'(p), 1'b0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      idle(); out_ready_i = 1;
      chk("tp3_order", out_id_o, k);
      cycle();
    end
    idle(); cycle();

    // Same-tag conflict: lowest port index wins.
    do_reset();
    idle(); alloc_valid_i = 1; cycle();
    idle(); set_port(1, 0, 32'h1111_1111, 5'b0, 1'b0); set_port(2, 0, 32'h2222_2222, 5'b0, 1'b0); cycle();
    idle();
    chk("conflict_res", result_o, 32'h1111_1111);
    out_ready_i = 1; cycle();

    // Back-pressure: head must hold for 5 cycles.
    do_reset();
    idle(); alloc_valid_i = 1; cycle();
    idle(); set_port(0, 0, 32'hFEED_F00D, 5'b01000, 1'b1); cycle();
    repeat (5) begin
      idle();
      chk("tp4_hold_v", out_valid_o, 1);
      chk("tp4_hold_res", result_o, 32'hFEED_F00D);
      cycle();
    end
    idle(); out_ready_i = 1; cycle();
    idle(); chk("tp4_retired", busy_o, 0); cycle();

    // Flush with 5 in flight; a stale completion afterwards is ignored.
    do_reset();
    repeat (5) begin idle(); alloc_valid_i = 1; cycle(); end
    idle(); set_port(0, 1, 32'h55, 5'b0, 1'b0); cycle();
    idle(); flush_i = 1; alloc_valid_i = 1; set_port(0, 0, 32'h66, 5'b0, 1'b0); cycle();
    idle();
    chk("tp5_busy", busy_o, 0);
    chk("tp5_valid", out_valid_o, 0);
    chk("tp5_id", alloc_id_o, 0);
    set_port(0, 3, 32'h77, 5'b0, 1'b0); cycle();
    idle(); chk("tp5_stale", out_valid_o, 0); cycle();

    // Sticky flags accumulate, then clear concurrent with a retire.
    do_reset();
    repeat (3) begin idle(); alloc_valid_i = 1; cycle(); end
    idle();
    set_port(0, 0, 32'h10, 5'b00001, 1'b0);
    set_port(1, 1, 32'h11, 5'b10000, 1'b0);
    set_port(2, 2, 32'h12, 5'b00100, 1'b0);
    cycle();
    idle(); out_ready_i = 1; cycle(); cycle();
    idle(); chk("tp6_ff", fflags_o, 5'b10001);
    out_ready_i = 1; fflags_clr_i = 1; cycle();
    idle(); chk("tp6_clr", fflags_o, 5'b00100); cycle();

    // Asynchronous reset mid-stream with a valid head and non-zero flags.
    idle(); alloc_valid_i = 1; cycle(); cycle();
    idle(); set_port(0, 3, 32'hDEAD_BEEF, 5'b00010, 1'b1); cycle();
    idle(); alloc_valid_i = 1;
    chk("pre_rst_v", out_valid_o, 1);
    #2;
    rst_i = 1;
    #1;
    chk("arst_alloc_ready", alloc_ready_o, 1);
    chk("arst_alloc_id", alloc_id_o, 0);
    chk("arst_opg_ready", opg_ready_o, 4'hF);
    chk("arst_out_valid", out_valid_o, 0);
    chk("arst_result", result_o, 0);
    chk("arst_status", status_o, 0);
    chk("arst_ext", extension_bit_o, 0);
    chk("arst_out_id", out_id_o, 0);
    chk("arst_fflags", fflags_o, 0);
    chk("arst_busy", busy_o, 0);
    model_reset();
    idle();
    @(posedge clk);
    @(negedge clk);
    rst_i = 0;

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      idle();
      alloc_valid_i = ($urandom_range(99) < 60);
      out_ready_i   = ($urandom_range(99) < 70);
      flush_i       = ($urandom_range(99) < 2);
      fflags_clr_i  = ($urandom_range(99) < 5);
      for (int p = 0; p < NG; p++) begin
        if ($urandom_range(99) < 40) begin
          int id;
          if (q.size() > 0 && $urandom_range(3) != 0) id = q[$urandom_range(q.size() - 1)];
          else id = $urandom_range(D - 1);
          set_port(p, id, $urandom, 5'($urandom_range(31)), 1'($urandom_range(1)));
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
